// File: rtl/popvote_unit.sv
// popvote_unit: sequential popcount / odd parity / threshold majority / inverted LSB over a valid/ready handshake.
// Optional feature: define POPVOTE_ABORT_EN to add a synchronous active-high `abort` input.
module popvote_unit #(
    parameter int WIDTH  = 8,
    parameter int CHUNK  = 2,
    parameter int THRESH = WIDTH / 2 + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef POPVOTE_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] out_count,
    output logic                       out_parity,
    output logic                       out_major,
    output logic                       out_inv_lsb
);

    localparam int CW    = $clog2(WIDTH + 1);
    localparam int BEATS = WIDTH / CHUNK;
    localparam int BW    = $clog2(BEATS + 1);

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0 ||
        THRESH < 1 || THRESH > WIDTH) begin : g_param_check
        $error("popvote_unit: illegal WIDTH/CHUNK/THRESH combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    chunk_ones;
    logic [CW-1:0]    cnt_sum;
    logic [BW-1:0]    beats;
    logic             live;
    logic             abort_req;
    logic             load;
    logic             step;
    logic             last_beat;

`ifdef POPVOTE_ABORT_EN
    assign abort_req = abort && (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // live holds in_ready low while reset is asserted and rises on the first edge after release.
    assign in_ready  = live && (state == IDLE);
    assign out_valid = (state == DONE);
    assign load      = in_valid && in_ready;
    assign step      = (state == BUSY);
    assign last_beat = step && (beats == BW'(1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        chunk_ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_ones = chunk_ones + CW'(shreg[i]);
        end
        cnt_sum = cnt + chunk_ones;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (load)       state_nxt = BUSY;
            BUSY:    if (last_beat)  state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
        if (abort_req) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so outputs read 0 during reset rather than stale data.
            live        <= 1'b0;
            shreg       <= '0;
            cnt         <= '0;
            beats       <= '0;
            out_count   <= '0;
            out_parity  <= 1'b0;
            out_major   <= 1'b0;
            out_inv_lsb <= 1'b0;
        end else begin
            live <= 1'b1;
            if (load) begin
                shreg       <= in_data;
                cnt         <= '0;
                beats       <= BW'(BEATS);
                out_inv_lsb <= ~in_data[0];
            end else if (step) begin
                shreg <= shreg >> CHUNK;
                cnt   <= cnt_sum;
                beats <= beats - BW'(1);
                if (last_beat) begin
                    out_count  <= cnt_sum;
                    out_parity <= cnt_sum[0];
                    out_major  <= (cnt_sum >= CW'(THRESH));
                end
            end
        end
    end

endmodule

// File: tb/tb_popvote_unit.sv
// Scoreboard bench for popvote_unit: directed vectors on the default config plus CHUNK=1 / CHUNK=8 sweeps.
module tb_popvote_unit;

    localparam int LAT    = 4;
    localparam int THRESH = 5;

    typedef struct {
        logic [3:0] count;
        logic       parity;
        logic       major;
        logic       inv;
        int         acc_cyc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] count;
        logic       parity;
        logic       major;
        logic       inv;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       sweep_rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_count;
    logic       out_parity;
    logic       out_major;
    logic       out_inv_lsb;
`ifdef POPVOTE_ABORT_EN
    logic       abort;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    popvote_unit #(.WIDTH(8), .CHUNK(2), .THRESH(THRESH)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef POPVOTE_ABORT_EN
        .abort       (abort),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .out_parity  (out_parity),
        .out_major   (out_major),
        .out_inv_lsb (out_inv_lsb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d, input int acc);
        exp_t m;
        m.count   = 4'($countones(d));
        m.parity  = ^d;
        m.major   = ($countones(d) >= THRESH);
        m.inv     = ~d[0];
        m.acc_cyc = acc;
        return m;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send(input vec_t v, input bit push);
        int   t;
        exp_t e;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 0, 1);
        in_data  = v.data;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.count   = v.count;
            e.parity  = v.parity;
            e.major   = v.major;
            e.inv     = v.inv;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) check("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("drain_timeout", 0, 1);
    endtask

    // Monitor: pops one expectation per presented result and rechecks it every cycle it is held.
    exp_t cur;
    bit   have_cur = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || !out_valid) begin
            have_cur = 1'b0;
        end else begin
            if (!have_cur) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("latency", cyc - cur.acc_cyc, LAT);
                end
            end
            if (have_cur) begin
                check("out_count", out_count, cur.count);
                check("out_parity", out_parity, cur.parity);
                check("out_major", out_major, cur.major);
                check("out_inv_lsb", out_inv_lsb, cur.inv);
                check("in_ready_while_done", in_ready, 0);
            end
        end
    end

    // Parameter sweep: CHUNK=1 (latency 8) and CHUNK=8 (latency 1) against a popcount model.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int CH   = (g == 0) ? 1 : 8;
        localparam int SLAT = 8 / CH;

        logic       s_in_valid;
        logic       s_in_ready;
        logic [7:0] s_in_data;
        logic       s_out_valid;
        logic [3:0] s_count;
        logic       s_par;
        logic       s_maj;
        logic       s_inv;
        exp_t       q[$];
        bit         done = 1'b0;

        popvote_unit #(.WIDTH(8), .CHUNK(CH), .THRESH(THRESH)) u_sweep (
            .clk         (clk),
            .rst_n       (sweep_rst_n),
`ifdef POPVOTE_ABORT_EN
            .abort       (1'b0),
`endif
            .in_valid    (s_in_valid),
            .in_ready    (s_in_ready),
            .in_data     (s_in_data),
            .out_valid   (s_out_valid),
            .out_ready   (1'b1),
            .out_count   (s_count),
            .out_parity  (s_par),
            .out_major   (s_maj),
            .out_inv_lsb (s_inv)
        );

        initial begin
            int t;
            s_in_valid = 1'b0;
            s_in_data  = '0;
            @(posedge sweep_rst_n);
            @(posedge clk); #1;
            for (int i = 0; i < 200; i++) begin
                t = 0;
                while (!s_in_ready && t < 50) begin
                    @(posedge clk); #1;
                    t++;
                end
                if (t >= 50) check($sformatf("sweep%0d_ready_timeout", CH), 0, 1);
                s_in_data  = 8'($urandom);
                s_in_valid = 1'b1;
                @(posedge clk); #1;
                s_in_valid = 1'b0;
                q.push_back(model(s_in_data, cyc));
            end
            t = 0;
            while ((q.size() != 0 || s_out_valid) && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            done = 1'b1;
        end

        always @(negedge clk) begin
            exp_t e;
            if (sweep_rst_n && s_out_valid) begin
                if (q.size() == 0) begin
                    check($sformatf("sweep%0d_unexpected", CH), 1, 0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("sweep%0d_latency", CH), cyc - e.acc_cyc, SLAT);
                    check($sformatf("sweep%0d_count", CH), s_count, e.count);
                    check($sformatf("sweep%0d_parity", CH), s_par, e.parity);
                    check($sformatf("sweep%0d_major", CH), s_maj, e.major);
                    check($sformatf("sweep%0d_inv_lsb", CH), s_inv, e.inv);
                end
            end
        end
    end

    vec_t vecs[7];
    vec_t v;

    initial begin
        int t;
        vecs[0] = '{8'hB5, 4'd5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h0F, 4'd4, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 4'd8, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h1F, 4'd5, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h1E, 4'd4, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h02, 4'd1, 1'b1, 1'b0, 1'b1};

        rst_n       = 1'b1;
        sweep_rst_n = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
`ifdef POPVOTE_ABORT_EN
        abort       = 1'b0;
`endif
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_major", out_major, 0);
        #3;
        rst_n       = 1'b1;
        sweep_rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Directed vectors back to back with out_ready tied high.
        for (int i = 0; i < 7; i++) send(vecs[i], 1'b1);
        wait_drain();

        // Backpressure: result held for 5 cycles, then released.
        out_ready = 1'b0;
        send(vecs[0], 1'b1);
        wait_valid();
        repeat (5) @(posedge clk);
        #1;
        check("bp_held_valid", out_valid, 1);
        check("bp_held_count", out_count, 5);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        send(vecs[3], 1'b1);
        wait_valid();
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_count", out_count, 0);
        check("async_rst_major", out_major, 0);
        check("async_rst_in_ready", in_ready, 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("async_rst_release_ready", in_ready, 1);

        // Reset two cycles after acceptance: no result may appear.
        v = '{8'hAA, 4'd4, 1'b0, 1'b0, 1'b1};
        send(v, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);

`ifdef POPVOTE_ABORT_EN
        // Abort while BUSY: back to IDLE on the next edge, no result.
        v = '{8'h55, 4'd4, 1'b0, 1'b0, 1'b0};
        send(v, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy_in_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        check("abort_busy_no_valid", out_valid, 0);

        // Abort in DONE together with a handshake.
        out_ready = 1'b0;
        v = '{8'h77, 4'd6, 1'b0, 1'b1, 1'b0};
        send(v, 1'b1);
        wait_valid();
        @(negedge clk); #1;
        abort     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_done_valid", out_valid, 0);
        check("abort_done_in_ready", in_ready, 1);
`endif

        wait_drain();
        t = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 5000) check("sweep_timeout", 0, 1);
        check("main_queue_empty", exp_q.size(), 0);
        check("sweep1_queue_empty", g_sweep[0].q.size(), 0);
        check("sweep8_queue_empty", g_sweep[1].q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
